// File: rtl/rc4_stream_if.sv
// Handshake bundle for rc4_stream: key load channel, plaintext in, ciphertext out, status.
interface rc4_stream_if;
  logic       key_vld;
  logic [7:0] key_data;
  logic       key_last;
  logic       key_rdy;
  logic       in_vld;
  logic [7:0] in_data;
  logic       in_rdy;
  logic       out_vld;
  logic [7:0] out_data;
  logic       out_rdy;
  logic       ks_ready;
  logic       key_ovf;

  modport master (
    output key_vld, key_data, key_last, in_vld, in_data, out_rdy,
    input  key_rdy, in_rdy, out_vld, out_data, ks_ready, key_ovf
  );

  modport slave (
    input  key_vld, key_data, key_last, in_vld, in_data, out_rdy,
    output key_rdy, in_rdy, out_vld, out_data, ks_ready, key_ovf
  );
endinterface

// File: rtl/rc4_stream.sv
// RC4 engine: key load, 256-cycle init, 256-cycle KSA, then one keystream byte per accepted input.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes after KSA (RC4-drop[N]).
module rc4_stream #(
  parameter int KEY_BYTES_MAX = 16,
  parameter int DROP_N        = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  rc4_stream_if.slave  bus
);

  localparam int LW = $clog2(KEY_BYTES_MAX + 1);
  localparam int KW = (KEY_BYTES_MAX > 1) ? $clog2(KEY_BYTES_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    KSA,
`ifdef RC4_DROP_EN
    DROP,
`endif
    RUN
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [7:0]     r_i;
  logic [7:0]     r_j;
  logic [LW-1:0]  r_len;
  logic [LW-1:0]  r_kidx;
  logic           r_key_ovf;
  logic           r_out_vld;
  logic [7:0]     r_out_data;
  logic [7:0]     r_s [256];
  logic [7:0]     r_k [KEY_BYTES_MAX];

`ifdef RC4_DROP_EN
  logic [11:0]    r_drop_cnt;
`else
  localparam int unused_drop_n = DROP_N;
`endif

  logic           w_key_rdy;
  logic           w_in_rdy;
  logic           w_ks_ready;
  logic           w_key_acc;
  logic           w_in_acc;
  logic           w_key_first;
  logic           w_key_store;
  logic [KW-1:0]  w_kaddr;
  logic           w_prga_step;
  logic           w_swap;
  logic [7:0]     w_ia;
  logic [7:0]     w_sa;
  logic [7:0]     w_jb;
  logic [7:0]     w_sb;
  logic [7:0]     w_t;
  logic [7:0]     w_ks;

  // A key byte accepted in IDLE or RUN starts a fresh key as K[0].
  assign w_key_acc   = bus.key_vld && w_key_rdy;
  assign w_in_acc    = bus.in_vld && w_in_rdy;
  assign w_key_first = (r_state == IDLE) || (r_state == RUN);
  assign w_key_store = w_key_first || (r_len < LW'(KEY_BYTES_MAX));
  assign w_kaddr     = w_key_first ? KW'(0) : r_len[KW-1:0];

`ifdef RC4_DROP_EN
  assign w_prga_step = (r_state == DROP) || ((r_state == RUN) && w_in_acc);
`else
  assign w_prga_step = (r_state == RUN) && w_in_acc;
`endif
  assign w_swap = (r_state == KSA) || w_prga_step;

  // Shared swap datapath: KSA uses (i, j+S[i]+K), PRGA uses (i+1, j+S[i+1]).
  assign w_ia = (r_state == KSA) ? r_i : r_i + 8'd1;
  assign w_sa = r_s[w_ia];
  assign w_jb = r_j + w_sa + ((r_state == KSA) ? r_k[r_kidx[KW-1:0]] : 8'd0);
  assign w_sb = r_s[w_jb];
  assign w_t  = w_sa + w_sb;
  assign w_ks = (w_t == w_ia) ? w_sb : (w_t == w_jb) ? w_sa : r_s[w_t];

  always_comb begin
    w_state_next = r_state;
    w_key_rdy    = 1'b0;
    w_in_rdy     = 1'b0;
    w_ks_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_key_rdy = 1'b1;
        if (w_key_acc) w_state_next = bus.key_last ? INIT : LOAD;
      end
      LOAD: begin
        w_key_rdy = 1'b1;
        if (w_key_acc && bus.key_last) w_state_next = INIT;
      end
      INIT: begin
        if (r_i == 8'hFF) w_state_next = KSA;
      end
      KSA: begin
`ifdef RC4_DROP_EN
        if (r_i == 8'hFF) w_state_next = (DROP_N == 0) ? RUN : DROP;
`else
        if (r_i == 8'hFF) w_state_next = RUN;
`endif
      end
`ifdef RC4_DROP_EN
      DROP: begin
        if (r_drop_cnt == 12'(DROP_N - 1)) w_state_next = RUN;
      end
`endif
      RUN: begin
        w_ks_ready = 1'b1;
        w_key_rdy  = !r_out_vld;
        // A pending key byte wins over plaintext in the same cycle.
        w_in_rdy   = (!r_out_vld || bus.out_rdy) && !bus.key_vld;
        if (w_key_acc) w_state_next = bus.key_last ? INIT : LOAD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_i        <= 8'd0;
      r_j        <= 8'd0;
      r_len      <= '0;
      r_kidx     <= '0;
      r_key_ovf  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= 8'd0;
`ifdef RC4_DROP_EN
      r_drop_cnt <= 12'd0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        INIT: r_i <= r_i + 8'd1;
        KSA: begin
          r_i    <= r_i + 8'd1;
          r_j    <= (r_i == 8'hFF) ? 8'd0 : w_jb;
          r_kidx <= (r_kidx == r_len - LW'(1)) ? '0 : r_kidx + LW'(1);
`ifdef RC4_DROP_EN
          r_drop_cnt <= 12'd0;
`endif
        end
`ifdef RC4_DROP_EN
        DROP: begin
          r_i        <= w_ia;
          r_j        <= w_jb;
          r_drop_cnt <= r_drop_cnt + 12'd1;
        end
`endif
        RUN: begin
          if (w_in_acc) begin
            r_i <= w_ia;
            r_j <= w_jb;
          end
        end
        default: ;
      endcase
      if (w_key_acc) begin
        r_kidx <= '0;
        if (w_key_first) begin
          r_len     <= LW'(1);
          r_key_ovf <= 1'b0;
          r_i       <= 8'd0;
          r_j       <= 8'd0;
        end else if (r_len < LW'(KEY_BYTES_MAX)) begin
          r_len <= r_len + LW'(1);
        end else begin
          r_key_ovf <= 1'b1;
        end
      end
      if (w_in_acc) begin
        r_out_vld  <= 1'b1;
        r_out_data <= bus.in_data ^ w_ks;
      end else if (bus.out_rdy) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  // State and key arrays carry no reset; their contents are rebuilt on every key load.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_s[r_i] <= r_i;
    end else if (w_swap) begin
      r_s[w_ia] <= w_sb;
      r_s[w_jb] <= w_sa;
    end
    if (w_key_acc && w_key_store) r_k[w_kaddr] <= bus.key_data;
  end

  assign bus.key_rdy  = w_key_rdy;
  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_data = r_out_data;
  assign bus.ks_ready = w_ks_ready;
  assign bus.key_ovf  = r_key_ovf;

endmodule
